// File: rtl/stack_player_pkg.sv
// stack_player_pkg: state encoding and sizing helpers shared by stack_player
package stack_player_pkg;
  typedef enum logic [2:0] {IDLE, POP, LOAD, SHOW, GAP, FIN} state_t;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int count_w(input int depth);
    return clog2(depth + 1);
  endfunction
  // timer only ever holds max-1, so clog2(max) bits suffice; floor of 1 bit
  function automatic int timer_w(input int on_c, input int off_c);
    int m = on_c > off_c ? on_c : off_c;
    return m > 1 ? clog2(m) : 1;
  endfunction
  localparam int COUNT_W = count_w(16);
  localparam int TIMER_W = timer_w(16, 8);
endpackage

// File: rtl/stack_player_hold_timer.sv
// hold_timer: loadable down-counter that parks at zero and flags it
module hold_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/stack_player.sv
// stack_player: drains the LIFO on START, showing each symbol for ON_CYCLES
// followed by an OFF_CYCLES dark gap.
module stack_player
  import stack_player_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int DEPTH      = 16,
  parameter int ON_CYCLES  = 16,
  parameter int OFF_CYCLES = 8
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        START,
  input  logic                        ABORT,
  input  logic                        STK_EMPTY,
  input  logic [DATA_WIDTH-1:0]       STK_DATA,
  output logic                        STK_POP,
  output logic                        SYM_VALID,
  output logic [DATA_WIDTH-1:0]       SYM_DATA,
  output logic                        BUSY,
  output logic                        DONE,
  output logic [count_w(DEPTH)-1:0]   COUNT
);
  localparam int CW = count_w(DEPTH);
  localparam int TW = timer_w(ON_CYCLES, OFF_CYCLES);
  localparam logic [TW-1:0] ON_LD  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LD = TW'(OFF_CYCLES - 1);
  state_t state;
  logic t_zero;
  logic t_load;
  assign t_load  = state == LOAD || (state == SHOW && t_zero);
  assign STK_POP = state == POP && !ABORT;
  hold_timer #(.W(TW)) u_timer (
    .clk(CLK),
    .rst(RST),
    .load(t_load),
    .load_val(state == LOAD ? ON_LD : OFF_LD),
    .zero(t_zero)
  );
  // DONE and BUSY are registered from the next state so they line up with FIN
  always_ff @(posedge CLK)
    if (RST) begin
      state     <= IDLE;
      SYM_VALID <= 1'b0;
      SYM_DATA  <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      COUNT     <= '0;
    end else begin
      DONE <= 1'b0;
      if (state != IDLE && ABORT) begin
        state     <= IDLE;
        SYM_VALID <= 1'b0;
        BUSY      <= 1'b0;
      end else
        case (state)
          IDLE:
            if (START && !ABORT) begin
              COUNT <= '0;
              BUSY  <= 1'b1;
              DONE  <= STK_EMPTY;
              state <= STK_EMPTY ? FIN : POP;
            end
          POP: state <= LOAD;
          LOAD: begin
            SYM_DATA  <= STK_DATA;
            COUNT     <= COUNT == CW'(DEPTH) ? COUNT : COUNT + 1'b1;
            SYM_VALID <= 1'b1;
            state     <= SHOW;
          end
          SHOW:
            if (t_zero) begin
              SYM_VALID <= 1'b0;
              state     <= GAP;
            end
          GAP:
            if (t_zero) begin
              DONE  <= STK_EMPTY;
              state <= STK_EMPTY ? FIN : POP;
            end
          FIN: begin
            BUSY  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
    end
endmodule
